// File: rtl/sync_fifo_stat.sv
// Single-clock FIFO with arbitrary depth, fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable first-word-fall-through read.
module sync_fifo_stat #(
   parameter  int WIDTH     = 16,
   parameter  int DEPTH     = 8,
   parameter  int AFULL_TH  = DEPTH - 2,
   parameter  int AEMPTY_TH = 1,
   parameter  int FWFT      = 1,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_rvalid,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_afull,
   output logic             o_aempty,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    count_d;
   logic             push_ok, pop_ok;

   // Depth need not be a power of two, so wrap on an explicit compare.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
   endfunction

   // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      pop_ok     = i_pop & ~o_empty;
      push_ok    = i_push & (~o_full | pop_ok);
      count_next = count;
      if (push_ok && !pop_ok) begin
         count_next = count + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count - CW'(1);
      end
      count_d = i_flush ? '0 : count_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (i_flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= ptr_inc(wptr);
         if (pop_ok)  rptr <= ptr_inc(rptr);
      end
   end

   // Status flags are decoded from the next count so they move on the same edge as o_count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count    <= '0;
         o_full   <= 1'b0;
         o_empty  <= 1'b1;
         o_afull  <= (AFULL_TH == 0);
         o_aempty <= 1'b1;
      end else begin
         count    <= count_d;
         o_full   <= (count_d == DEPTH_C);
         o_empty  <= (count_d == '0);
         o_afull  <= (count_d >= AFULL_C);
         o_aempty <= (count_d <= AEMPTY_C);
      end
   end

   assign o_count = count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_flush) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (i_push && !push_ok) o_overflow  <= 1'b1;
         if (i_pop  && !pop_ok)  o_underflow <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; pointers and count define what is valid.
   always_ff @(posedge i_clk) begin
      if (push_ok && !i_flush && !i_rst) begin
         mem[wptr] <= i_wdata;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign o_rdata  = mem[rptr];
         assign o_rvalid = ~o_empty;
      end else begin : g_reg_read
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               o_rdata  <= '0;
               o_rvalid <= 1'b0;
            end else if (i_flush) begin
               o_rvalid <= 1'b0;
            end else begin
               o_rvalid <= pop_ok;
               if (pop_ok) o_rdata <= mem[rptr];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_stat.sv
// Scoreboard bench: a registered-read FIFO (DEPTH=8) and an FWFT FIFO (DEPTH=5).
module tb_sync_fifo_stat;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        a_rst, a_push, a_pop, a_flush;
   logic [15:0] a_wdata, a_rdata;
   logic        a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
   logic [3:0]  a_count;

   logic        b_rst, b_push, b_pop, b_flush;
   logic [15:0] b_wdata, b_rdata;
   logic        b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
   logic [2:0]  b_count;

   logic [15:0] qa[$];
   logic [15:0] qb[$];

   sync_fifo_stat #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u_a (
      .i_clk(clk), .i_rst(a_rst), .i_wdata(a_wdata), .i_push(a_push), .i_pop(a_pop),
      .i_flush(a_flush), .o_rdata(a_rdata), .o_rvalid(a_rvalid), .o_count(a_count),
      .o_full(a_full), .o_empty(a_empty), .o_afull(a_afull), .o_aempty(a_aempty),
      .o_overflow(a_ovf), .o_underflow(a_udf)
   );

   sync_fifo_stat #(.WIDTH(16), .DEPTH(5), .FWFT(1)) u_b (
      .i_clk(clk), .i_rst(b_rst), .i_wdata(b_wdata), .i_push(b_push), .i_pop(b_pop),
      .i_flush(b_flush), .o_rdata(b_rdata), .o_rvalid(b_rvalid), .o_count(b_count),
      .o_full(b_full), .o_empty(b_empty), .o_afull(b_afull), .o_aempty(b_aempty),
      .o_overflow(b_ovf), .o_underflow(b_udf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Registered-read monitor: every rvalid pulse must carry the oldest expected word.
   always @(negedge clk) begin
      if (a_rvalid === 1'b1) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_rdata_unexpected: got %h expected none", a_rdata);
         end else begin
            logic [15:0] exp_a;
            exp_a = qa.pop_front();
            check("a_rdata", 32'(a_rdata), 32'(exp_a));
         end
      end
   end

   // FWFT monitor: the head word is consumed when pop is presented while valid.
   always @(negedge clk) begin
      if (b_pop === 1'b1 && b_rvalid === 1'b1) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_rdata_unexpected: got %h expected none", b_rdata);
         end else begin
            logic [15:0] exp_b;
            exp_b = qb.pop_front();
            check("b_rdata", 32'(b_rdata), 32'(exp_b));
         end
      end
   end

   initial begin
      a_rst = 1'b1; a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_wdata = '0;
      b_rst = 1'b1; b_push = 1'b0; b_pop = 1'b0; b_flush = 1'b0; b_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      a_rst = 1'b0;
      b_rst = 1'b0;

      check("a_rst_count",  32'(a_count),  32'd0);
      check("a_rst_empty",  32'(a_empty),  32'd1);
      check("a_rst_aempty", 32'(a_aempty), 32'd1);
      check("a_rst_full",   32'(a_full),   32'd0);
      check("a_rst_afull",  32'(a_afull),  32'd0);
      check("a_rst_flags",  32'({a_ovf, a_udf}), 32'd0);
      check("a_rst_rvalid", 32'(a_rvalid), 32'd0);
      check("a_rst_rdata",  32'(a_rdata),  32'd0);
      check("b_rst_count",  32'(b_count),  32'd0);
      check("b_rst_rvalid", 32'(b_rvalid), 32'd0);

      // Fill DEPTH=8 with 1..8, then drain
      for (int i = 1; i <= 8; i++) begin
         a_push = 1'b1; a_wdata = 16'(i); qa.push_back(16'(i));
         step();
         check("a_fill_count",  32'(a_count),  32'(i));
         check("a_fill_afull",  32'(a_afull),  32'(i >= 6));
         check("a_fill_full",   32'(a_full),   32'(i == 8));
         check("a_fill_aempty", 32'(a_aempty), 32'(i <= 1));
      end
      a_push = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         a_pop = 1'b1;
         step();
         check("a_drain_count", 32'(a_count), 32'(8 - i));
         check("a_drain_empty", 32'(a_empty), 32'(i == 8));
      end
      a_pop = 1'b0;
      step();
      check("a_idle_rvalid", 32'(a_rvalid), 32'd0);

      // Registered read latency
      a_push = 1'b1; a_wdata = 16'h1234; qa.push_back(16'h1234);
      step();
      a_push = 1'b0;
      check("a_nopop_rvalid", 32'(a_rvalid), 32'd0);
      a_pop = 1'b1;
      step();
      a_pop = 1'b0;
      check("a_pop_rvalid", 32'(a_rvalid), 32'd1);
      check("a_pop_rdata",  32'(a_rdata),  32'h1234);
      step();
      check("a_pulse_end",  32'(a_rvalid), 32'd0);
      check("a_rdata_hold", 32'(a_rdata),  32'h1234);

      // Set both error flags with count=4, then flush with a push
      a_pop = 1'b1;
      step();
      a_pop = 1'b0;
      check("a_udf_set",   32'(a_udf),   32'd1);
      check("a_udf_count", 32'(a_count), 32'd0);
      for (int i = 0; i < 8; i++) begin
         a_push = 1'b1; a_wdata = 16'(16'h20 + i); qa.push_back(16'(16'h20 + i));
         step();
      end
      a_wdata = 16'h0099;
      step();
      a_push = 1'b0;
      check("a_ovf_set",   32'(a_ovf),   32'd1);
      check("a_ovf_count", 32'(a_count), 32'd8);
      a_pop = 1'b1;
      repeat (4) step();
      a_pop = 1'b0;
      step();
      check("a_pre_flush_count", 32'(a_count), 32'd4);
      check("a_pre_flush_flags", 32'({a_ovf, a_udf}), 32'b11);
      a_flush = 1'b1; a_push = 1'b1; a_wdata = 16'h0055;
      step();
      qa.delete();
      check("a_flush_count",  32'(a_count), 32'd0);
      check("a_flush_empty",  32'(a_empty), 32'd1);
      check("a_flush_flags",  32'({a_ovf, a_udf}), 32'd0);
      check("a_flush_rvalid", 32'(a_rvalid), 32'd0);
      a_flush = 1'b0; a_push = 1'b0;
      step();
      check("a_flush_push_ignored", 32'(a_count), 32'd0);

      // Mid-burst asynchronous reset
      for (int i = 0; i < 3; i++) begin
         a_push = 1'b1; a_wdata = 16'(16'h30 + i); qa.push_back(16'(16'h30 + i));
         step();
      end
      a_wdata = 16'h0033; a_pop = 1'b1; qa.push_back(16'h0033);
      step();
      check("a_burst_rvalid", 32'(a_rvalid), 32'd1);
      check("a_burst_count",  32'(a_count),  32'd3);
      #1 a_rst = 1'b1;
      #1;
      qa.delete();
      check("a_mid_rst_count",  32'(a_count),  32'd0);
      check("a_mid_rst_status", 32'({a_empty, a_aempty, a_full, a_afull}), 32'b1100);
      check("a_mid_rst_flags",  32'({a_ovf, a_udf}), 32'd0);
      check("a_mid_rst_rvalid", 32'(a_rvalid), 32'd0);
      check("a_mid_rst_rdata",  32'(a_rdata),  32'd0);
      a_push = 1'b0; a_pop = 1'b0;
      #1 a_rst = 1'b0;
      step();
      check("a_post_rst_count", 32'(a_count), 32'd0);

      // FWFT visibility without pop
      b_push = 1'b1; b_wdata = 16'h1234; qb.push_back(16'h1234);
      step();
      b_push = 1'b0;
      check("b_fwft_rvalid", 32'(b_rvalid), 32'd1);
      check("b_fwft_rdata",  32'(b_rdata),  32'h1234);
      check("b_fwft_count",  32'(b_count),  32'd1);
      step();
      check("b_fwft_hold", 32'(b_rdata), 32'h1234);
      b_pop = 1'b1;
      step();
      b_pop = 1'b0;
      check("b_fwft_empty", 32'({b_empty, b_rvalid}), 32'b10);

      // DEPTH=5 wrap: push 5, pop 3, push 3, pop 5
      for (int i = 0; i < 5; i++) begin
         b_push = 1'b1; b_wdata = 16'(16'h41 + i); qb.push_back(16'(16'h41 + i));
         step();
      end
      b_push = 1'b0;
      check("b_wrap_full",  32'({b_full, b_afull}), 32'b11);
      check("b_wrap_count", 32'(b_count), 32'd5);
      b_pop = 1'b1;
      repeat (3) step();
      b_pop = 1'b0;
      check("b_wrap_mid_count", 32'(b_count), 32'd2);
      for (int i = 0; i < 3; i++) begin
         b_push = 1'b1; b_wdata = 16'(16'h46 + i); qb.push_back(16'(16'h46 + i));
         step();
      end
      b_push = 1'b0;
      check("b_wrap_refill", 32'(b_count), 32'd5);
      b_pop = 1'b1;
      repeat (5) step();
      b_pop = 1'b0;
      check("b_wrap_end_count", 32'(b_count), 32'd0);
      check("b_wrap_end_empty", 32'(b_empty), 32'd1);

      // Overflow on full, then simultaneous push+pop while full
      for (int i = 0; i < 5; i++) begin
         b_push = 1'b1; b_wdata = 16'(16'h51 + i); qb.push_back(16'(16'h51 + i));
         step();
      end
      b_wdata = 16'hBEEF;
      step();
      check("b_ovf_set",   32'(b_ovf),   32'd1);
      check("b_ovf_count", 32'(b_count), 32'd5);
      b_wdata = 16'h0056; b_pop = 1'b1; qb.push_back(16'h0056);
      step();
      b_push = 1'b0;
      check("b_full_pushpop_count", 32'(b_count), 32'd5);
      repeat (5) step();
      b_pop = 1'b0;
      check("b_ovf_drain_empty", 32'(b_empty), 32'd1);

      // Underflow on empty, then push+pop while empty
      b_pop = 1'b1;
      step();
      b_pop = 1'b0;
      check("b_udf_set",   32'(b_udf),   32'd1);
      check("b_udf_count", 32'(b_count), 32'd0);
      b_push = 1'b1; b_pop = 1'b1; b_wdata = 16'h00AA; qb.push_back(16'h00AA);
      step();
      b_push = 1'b0; b_pop = 1'b0;
      check("b_empty_pushpop_count", 32'(b_count), 32'd1);
      check("b_empty_pushpop_rdata", 32'(b_rdata), 32'h00AA);
      b_pop = 1'b1;
      step();
      b_pop = 1'b0;
      check("b_final_count", 32'(b_count), 32'd0);

      step();
      check("a_scoreboard_drained", 32'(qa.size()), 32'd0);
      check("b_scoreboard_drained", 32'(qb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
